// File: rtl/pong_pkg.sv
// Shared pong geometry defaults and game state encoding for the ball, padder and direction control.
// Latency: none (declarations only); backpressure: n/a.
package pong_pkg;

  localparam int SCREEN_W_DEF   = 430;
  localparam int SCREEN_H_DEF   = 768;
  localparam int BALL_SIZE_DEF  = 6;
  localparam int BALL_SPEED_DEF = 2;
  localparam int PAD_Y_DEF      = 748;
  localparam int PAD_H_DEF      = 6;
  localparam int PAD_WIDTH_DEF  = 40;
  localparam int LIVES_DEF      = 3;

  localparam int CMP_W = 11;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  function automatic logic [CMP_W-1:0] cmp_const(input int v);
    return CMP_W'(v);
  endfunction

endpackage

// File: rtl/ball_dir_ctrl_hit_detect.sv
// Combinational wall/paddle/floor contact detection; only directions pointing into a surface are checked.
// Latency: 0 cycles (pure logic); backpressure: none.
module ball_hit_detect
  import pong_pkg::*;
#(
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int BALL_SIZE  = BALL_SIZE_DEF,
  parameter int BALL_SPEED = BALL_SPEED_DEF,
  parameter int PAD_Y      = PAD_Y_DEF,
  parameter int PAD_H      = PAD_H_DEF,
  parameter int PAD_WIDTH  = PAD_WIDTH_DEF
) (
  input  logic [8:0] ball_xpos,
  input  logic [9:0] ball_ypos,
  input  logic [8:0] pad_xpos,
  input  logic       direction_x,
  input  logic       direction_y,
  output logic       hit_left,
  output logic       hit_right,
  output logic       hit_top,
  output logic       hit_pad,
  output logic       miss
);

  localparam logic [CMP_W-1:0] EDGE_MARGIN = cmp_const(2 * BALL_SPEED);
  localparam logic [CMP_W-1:0] SIZE        = cmp_const(BALL_SIZE);
  localparam logic [CMP_W-1:0] RIGHT_LIM   = cmp_const(SCREEN_W - 2 * BALL_SPEED);
  localparam logic [CMP_W-1:0] FLOOR_LIM   = cmp_const(SCREEN_H - 2 * BALL_SPEED);
  localparam logic [CMP_W-1:0] PAD_TOP_LIM = cmp_const(PAD_Y - BALL_SPEED);
  localparam logic [CMP_W-1:0] PAD_BOT_LIM = cmp_const(PAD_Y + PAD_H);
  localparam logic [CMP_W-1:0] PAD_W       = cmp_const(PAD_WIDTH);

  logic [CMP_W-1:0] bx, by, px;
  logic [CMP_W-1:0] bx_right, by_bottom, px_right;
  logic             pad_contact;
  logic             floor_contact;

  always_comb begin
    bx        = {2'b00, ball_xpos};
    by        = {1'b0, ball_ypos};
    px        = {2'b00, pad_xpos};
    bx_right  = bx + SIZE;
    by_bottom = by + SIZE;
    px_right  = px + PAD_W;

    hit_left  = !direction_x && (bx < EDGE_MARGIN);
    hit_right =  direction_x && (bx_right > RIGHT_LIM);
    hit_top   = !direction_y && (by < EDGE_MARGIN);

    pad_contact = direction_y
               && (by_bottom >= PAD_TOP_LIM)
               && (by_bottom <  PAD_BOT_LIM)
               && (bx_right  >  px)
               && (bx        <  px_right);
    floor_contact = direction_y && (by_bottom >= FLOOR_LIM);

    // A paddle return always takes precedence over a floor miss.
    hit_pad = pad_contact;
    miss    = floor_contact && !pad_contact;
  end

endmodule

// File: rtl/ball_dir_ctrl.sv
// Ball direction, score/lives and serve/play/miss/over sequencing for the ball motion block.
// Latency: contact to direction/score change 1 cycle, all outputs registered; backpressure: none.
module ball_dir_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int BALL_SIZE  = BALL_SIZE_DEF,
  parameter int BALL_SPEED = BALL_SPEED_DEF,
  parameter int PAD_Y      = PAD_Y_DEF,
  parameter int PAD_H      = PAD_H_DEF,
  parameter int PAD_WIDTH  = PAD_WIDTH_DEF,
  parameter int LIVES      = LIVES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] ball_xpos,
  input  logic [9:0] ball_ypos,
  input  logic [8:0] pad_xpos,
  input  logic       serve,
  output logic       direction_x,
  output logic       direction_y,
  output logic       ball_reset,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  game_state_t state;
  logic        serve_side;
  logic        hit_left, hit_right, hit_top, hit_pad, miss;

  ball_hit_detect #(
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H),
    .BALL_SIZE  (BALL_SIZE),
    .BALL_SPEED (BALL_SPEED),
    .PAD_Y      (PAD_Y),
    .PAD_H      (PAD_H),
    .PAD_WIDTH  (PAD_WIDTH)
  ) u_hit (
    .ball_xpos   (ball_xpos),
    .ball_ypos   (ball_ypos),
    .pad_xpos    (pad_xpos),
    .direction_x (direction_x),
    .direction_y (direction_y),
    .hit_left    (hit_left),
    .hit_right   (hit_right),
    .hit_top     (hit_top),
    .hit_pad     (hit_pad),
    .miss        (miss)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SERVE;
      direction_x <= 1'b1;
      direction_y <= 1'b1;
      score       <= 8'd0;
      lives       <= LIVES_INIT;
      serve_side  <= 1'b1;
    end else begin
      unique case (state)
        SERVE: begin
          if (serve) begin
            direction_x <= serve_side;
            direction_y <= 1'b1;
            state       <= PLAY;
          end
        end
        PLAY: begin
          // x and y contacts are independent, so a corner flips both axes at once.
          if (hit_left)
            direction_x <= 1'b1;
          else if (hit_right)
            direction_x <= 1'b0;
          if (hit_top) begin
            direction_y <= 1'b1;
          end else if (hit_pad) begin
            direction_y <= 1'b0;
            if (score != 8'hFF)
              score <= score + 8'd1;
          end else if (miss) begin
            state <= MISS;
          end
        end
        MISS: begin
          lives      <= lives - 2'd1;
          serve_side <= ~serve_side;
          state      <= (lives == 2'd1) ? OVER : SERVE;
        end
        OVER: begin
          if (serve) begin
            lives <= LIVES_INIT;
            score <= 8'd0;
            state <= SERVE;
          end
        end
        default: state <= SERVE;
      endcase
    end
  end

  // Decoded straight from the state register: no combinational input path.
  assign ball_reset = (state != PLAY);
  assign game_over  = (state == OVER);

endmodule

// File: tb/tb_ball_dir_ctrl.sv
// Directed, table-driven check of ball_dir_ctrl contacts, scoring, lives and game sequencing.
module tb_ball_dir_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] ball_xpos;
  logic [9:0] ball_ypos;
  logic [8:0] pad_xpos;
  logic       serve;
  logic       direction_x;
  logic       direction_y;
  logic       ball_reset;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;

  int tests = 0;
  int fails = 0;

  ball_dir_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .ball_xpos   (ball_xpos),
    .ball_ypos   (ball_ypos),
    .pad_xpos    (pad_xpos),
    .serve       (serve),
    .direction_x (direction_x),
    .direction_y (direction_y),
    .ball_reset  (ball_reset),
    .score       (score),
    .lives       (lives),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] bx;
    logic [9:0] by;
    logic [8:0] px;
    logic       dx;
    logic       dy;
    logic [7:0] sc;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_pos(input int bx, input int by, input int px);
    ball_xpos = 9'(bx);
    ball_ypos = 10'(by);
    pad_xpos  = 9'(px);
  endtask

  task automatic pulse_serve;
    serve = 1'b1;
    @(negedge clk);
    serve = 1'b0;
  endtask

  // Drive a floor contact, then check the MISS cycle and the state after it.
  task automatic do_miss(input int lives_after, input int over_after);
    set_pos(100, 760, 0);
    @(negedge clk);
    chk("miss_cycle_ball_reset", ball_reset, 1);
    chk("miss_cycle_game_over", game_over, 0);
    set_pos(100, 300, 0);
    @(negedge clk);
    chk("after_miss_lives", lives, lives_after);
    chk("after_miss_ball_reset", ball_reset, 1);
    chk("after_miss_game_over", game_over, over_after);
  endtask

  initial begin
    tbl[0]  = '{9'd100, 10'd300, 9'd0,   1'b1, 1'b1, 8'd0};
    tbl[1]  = '{9'd420, 10'd300, 9'd0,   1'b1, 1'b1, 8'd0};
    tbl[2]  = '{9'd422, 10'd300, 9'd0,   1'b0, 1'b1, 8'd0};
    tbl[3]  = '{9'd6,   10'd300, 9'd0,   1'b0, 1'b1, 8'd0};
    tbl[4]  = '{9'd4,   10'd300, 9'd0,   1'b0, 1'b1, 8'd0};
    tbl[5]  = '{9'd2,   10'd300, 9'd0,   1'b1, 1'b1, 8'd0};
    tbl[6]  = '{9'd2,   10'd300, 9'd0,   1'b1, 1'b1, 8'd0};
    tbl[7]  = '{9'd210, 10'd740, 9'd200, 1'b1, 1'b0, 8'd1};
    tbl[8]  = '{9'd210, 10'd740, 9'd200, 1'b1, 1'b0, 8'd1};
    tbl[9]  = '{9'd100, 10'd3,   9'd200, 1'b1, 1'b1, 8'd1};
    tbl[10] = '{9'd210, 10'd740, 9'd200, 1'b1, 1'b0, 8'd2};
    tbl[11] = '{9'd422, 10'd3,   9'd200, 1'b0, 1'b1, 8'd2};
    tbl[12] = '{9'd240, 10'd740, 9'd200, 1'b0, 1'b1, 8'd2};
    tbl[13] = '{9'd194, 10'd740, 9'd200, 1'b0, 1'b1, 8'd2};
    tbl[14] = '{9'd210, 10'd739, 9'd200, 1'b0, 1'b1, 8'd2};
    tbl[15] = '{9'd210, 10'd747, 9'd200, 1'b0, 1'b0, 8'd3};
    tbl[16] = '{9'd100, 10'd3,   9'd200, 1'b0, 1'b1, 8'd3};

    reset = 1'b1;
    serve = 1'b0;
    set_pos(100, 300, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_direction_x", direction_x, 1);
    chk("reset_direction_y", direction_y, 1);
    chk("reset_ball_reset", ball_reset, 1);
    chk("reset_score", score, 0);
    chk("reset_lives", lives, 3);
    chk("reset_game_over", game_over, 0);

    pulse_serve();
    chk("serve_ball_reset", ball_reset, 0);
    chk("serve_direction_x", direction_x, 1);
    chk("serve_direction_y", direction_y, 1);

    for (int i = 0; i < 17; i++) begin
      set_pos(int'(tbl[i].bx), int'(tbl[i].by), int'(tbl[i].px));
      @(negedge clk);
      chk($sformatf("vec%0d_direction_x", i), direction_x, tbl[i].dx);
      chk($sformatf("vec%0d_direction_y", i), direction_y, tbl[i].dy);
      chk($sformatf("vec%0d_score", i), score, tbl[i].sc);
      chk($sformatf("vec%0d_ball_reset", i), ball_reset, 0);
    end

    do_miss(2, 0);
    pulse_serve();
    chk("serve2_ball_reset", ball_reset, 0);
    chk("serve2_direction_x", direction_x, 0);
    chk("serve2_direction_y", direction_y, 1);

    do_miss(1, 0);
    pulse_serve();
    chk("serve3_direction_x", direction_x, 1);

    do_miss(0, 1);
    @(negedge clk);
    chk("over_holds", game_over, 1);
    pulse_serve();
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 0);
    chk("restart_game_over", game_over, 0);
    chk("restart_in_serve", ball_reset, 1);
    pulse_serve();
    chk("restart_play", ball_reset, 0);
    chk("restart_direction_x", direction_x, 0);

    for (int i = 0; i < 256; i++) begin
      set_pos(210, 740, 200);
      @(negedge clk);
      if (i == 254) chk("score_reaches_255", score, 255);
      set_pos(100, 3, 200);
      @(negedge clk);
    end
    chk("score_saturated", score, 255);
    chk("sat_direction_y", direction_y, 1);
    chk("sat_still_playing", ball_reset, 0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midplay_reset_ball_reset", ball_reset, 1);
    chk("midplay_reset_score", score, 0);
    chk("midplay_reset_lives", lives, 3);
    chk("midplay_reset_direction_x", direction_x, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
